// File: rtl/mx_pkg.sv
// Shared definitions for the BF16 -> MXINT streaming converter:
// BF16 field layout, E8M0 special code, FSM states and rounding modes.
package mx_pkg;

  localparam int BF16_W     = 16;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic [7:0] E8M0_NAN  = 8'hFF;
  localparam logic [7:0] EXP_SPECL = 8'hFF;

  typedef enum logic [1:0] {
    FILL,
    SCALE,
    DRAIN
  } state_t;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RNE   = 1'b1
  } rnd_mode_t;

endpackage

// File: rtl/bf16_to_mxint_elem.sv
// Converts one BF16 element to a bit_width-bit two's-complement MXINT
// element against a shared E8M0 exponent, with truncate or RNE rounding.
module bf16_to_mxint_elem
  import mx_pkg::*;
#(
  parameter int bit_width = 8
) (
  input  logic [BF16_W-1:0]    bf16,
  input  logic [7:0]           shared_exp,
  input  rnd_mode_t            mode,
  output logic [bit_width-1:0] mx
);

  // The significand is placed so the low FRAC bits are the fraction below
  // the integer result; with d < bit_width nothing is ever shifted out.
  localparam int FRAC = BF16_MAN_W + 1;
  localparam int VW   = bit_width + BF16_MAN_W;
  localparam logic [bit_width-1:0] MAX_MAG = {1'b0, {(bit_width-1){1'b1}}};

  logic [BF16_EXP_W-1:0] e;
  logic [BF16_MAN_W:0]   sig;
  logic [8:0]            d;
  logic [8:0]            shamt;
  logic [VW-1:0]         val;
  logic                  inc;
  logic [bit_width-1:0]  rounded;
  logic [bit_width-1:0]  mag;

  always_comb begin
    e       = bf16[BF16_W-2 -: BF16_EXP_W];
    sig     = {1'b1, bf16[BF16_MAN_W-1:0]};
    d       = {1'b0, shared_exp} - {1'b0, e};
    shamt   = 9'(bit_width - 1) - d;
    val     = '0;
    inc     = 1'b0;
    rounded = '0;
    mag     = '0;
    mx      = '0;
    if (shared_exp != E8M0_NAN && e != 8'h00 && e != EXP_SPECL && d < 9'(bit_width)) begin
      val     = VW'(sig) << shamt;
      inc     = (mode == RND_RNE) && val[FRAC-1] && ((|val[FRAC-2:0]) || val[FRAC]);
      rounded = {1'b0, val[VW-1:FRAC]} + bit_width'(inc);
      mag     = rounded[bit_width-1] ? MAX_MAG : rounded;
      mx      = bf16[BF16_W-1] ? -mag : mag;
    end
  end

endmodule

// File: rtl/conv_bf16tomxint_stream.sv
// Streaming BF16 -> MXINT block converter: fills a block buffer beat by beat
// while tracking the max exponent, then drains converted beats with backpressure.
module conv_bf16tomxint_stream
  import mx_pkg::*;
#(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 8,
  parameter int freq_mhz  = 100
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [BF16_W*lanes-1:0]    i_bf16_vec,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_round,
  output logic [bit_width*lanes-1:0] o_mx_vec,
  output logic [7:0]                 o_mx_exp,
  output logic                       o_valid,
  output logic                       o_last,
  input  logic                       i_ready
);

  localparam int BEATS = k / lanes;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (bit_width < 4 || (k % lanes) != 0 || freq_mhz <= 0) begin : g_bad_cfg
    $error("conv_bf16tomxint_stream: unsupported parameter set");
  end

  state_t                     state;
  logic [CNT_W-1:0]           beat_cnt;
  logic [CNT_W-1:0]           out_cnt;
  logic [7:0]                 emax_q;
  logic                       nan_q;
  rnd_mode_t                  round_q;
  logic [BF16_W*lanes-1:0]    beat_buf [BEATS];

  logic [7:0]                 beat_max;
  logic                       beat_nan;
  logic [7:0]                 exp_calc;
  logic [7:0]                 conv_exp;
  logic [CNT_W-1:0]           sel_beat;
  logic [BF16_W*lanes-1:0]    sel_data;
  logic [bit_width*lanes-1:0] conv_vec;
  logic                       in_fire;

  assign in_fire = (state == FILL) && i_valid && o_ready;

  // Zero/subnormal exponents never beat the running max, so they drop out naturally.
  always_comb begin
    beat_max = '0;
    beat_nan = 1'b0;
    for (int i = 0; i < lanes; i++) begin
      if (i_bf16_vec[BF16_W*i+BF16_MAN_W +: BF16_EXP_W] == EXP_SPECL) begin
        beat_nan = 1'b1;
      end else if (i_bf16_vec[BF16_W*i+BF16_MAN_W +: BF16_EXP_W] > beat_max) begin
        beat_max = i_bf16_vec[BF16_W*i+BF16_MAN_W +: BF16_EXP_W];
      end
    end
  end

  // During SCALE the exponent register is not yet loaded, so convert against the fresh value.
  always_comb begin
    exp_calc = nan_q ? E8M0_NAN : emax_q;
    conv_exp = (state == SCALE) ? exp_calc : o_mx_exp;
    sel_beat = (state == SCALE) ? '0 : out_cnt + CNT_W'(1);
    sel_data = beat_buf[sel_beat];
  end

  for (genvar g = 0; g < lanes; g++) begin : g_lane
    bf16_to_mxint_elem #(
      .bit_width (bit_width)
    ) u_elem (
      .bf16       (sel_data[BF16_W*g +: BF16_W]),
      .shared_exp (conv_exp),
      .mode       (round_q),
      .mx         (conv_vec[bit_width*g +: bit_width])
    );
  end

  always_ff @(posedge i_clk) begin
    if (in_fire) begin
      beat_buf[beat_cnt] <= i_bf16_vec;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= FILL;
      beat_cnt <= '0;
      out_cnt  <= '0;
      emax_q   <= '0;
      nan_q    <= 1'b0;
      round_q  <= RND_TRUNC;
      o_ready  <= 1'b0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_mx_vec <= '0;
      o_mx_exp <= '0;
    end else begin
      case (state)
        FILL: begin
          o_ready <= 1'b1;
          if (in_fire) begin
            emax_q <= (beat_max > emax_q) ? beat_max : emax_q;
            nan_q  <= nan_q | beat_nan;
            if (beat_cnt == '0) begin
              round_q <= rnd_mode_t'(i_round);
            end
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              o_ready  <= 1'b0;
              state    <= SCALE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        SCALE: begin
          o_mx_exp <= exp_calc;
          o_mx_vec <= conv_vec;
          o_valid  <= 1'b1;
          o_last   <= (LAST_BEAT == '0);
          out_cnt  <= '0;
          state    <= DRAIN;
        end
        DRAIN: begin
          if (i_ready) begin
            if (o_last) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              o_ready <= 1'b1;
              emax_q  <= '0;
              nan_q   <= 1'b0;
              state   <= FILL;
            end else begin
              o_mx_vec <= conv_vec;
              out_cnt  <= out_cnt + CNT_W'(1);
              o_last   <= (out_cnt + CNT_W'(1) == LAST_BEAT);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bf16tomxint_stream.sv
// Scoreboard bench for conv_bf16tomxint_stream: directed blocks push expected
// beats into a queue, a negedge monitor pops and compares each output handshake.
module tb_conv_bf16tomxint_stream;

  localparam int BW    = 8;
  localparam int K     = 32;
  localparam int LANES = 8;
  localparam int BEATS = K / LANES;

  typedef struct packed {
    logic [BW*LANES-1:0] vec;
    logic [7:0]          xexp;
    logic                last;
  } exp_beat_t;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic [16*LANES-1:0]  i_bf16_vec = '0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic                 i_round = 1'b0;
  logic [BW*LANES-1:0]  o_mx_vec;
  logic [7:0]           o_mx_exp;
  logic                 o_valid;
  logic                 o_last;
  logic                 i_ready = 1'b1;

  exp_beat_t   sb[$];
  logic [15:0] blk_in [K];
  logic [7:0]  exp_el [K];
  int          n_compared = 0;
  int          n_mismatched = 0;

  conv_bf16tomxint_stream #(
    .bit_width (BW),
    .k         (K),
    .lanes     (LANES),
    .freq_mhz  (100)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_bf16_vec (i_bf16_vec),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_round    (i_round),
    .o_mx_vec   (o_mx_vec),
    .o_mx_exp   (o_mx_exp),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .i_ready    (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Every output handshake is matched against the oldest expected beat.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        failNow("unexpected_beat");
      end else begin
        exp_beat_t e;
        e = sb.pop_front();
        checkOutput("beat_vec", 64'(o_mx_vec), 64'(e.vec));
        checkOutput("beat_exp", 64'(o_mx_exp), 64'(e.xexp));
        checkOutput("beat_last", 64'(o_last), 64'(e.last));
      end
    end
  end

  task automatic fillAll(input logic [15:0] v, input logic [7:0] x);
    for (int i = 0; i < K; i++) begin
      blk_in[i] = v;
      exp_el[i] = x;
    end
  endtask

  function automatic logic [BW*LANES-1:0] expBeat(input int b);
    logic [BW*LANES-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[BW*i +: BW] = exp_el[LANES*b+i];
    return v;
  endfunction

  task automatic pushExpected(input logic [7:0] xexp);
    for (int b = 0; b < BEATS; b++) begin
      exp_beat_t e;
      e.vec  = expBeat(b);
      e.xexp = xexp;
      e.last = (b == BEATS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic rnd, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      int cyc;
      for (int i = 0; i < LANES; i++) i_bf16_vec[16*i +: 16] = blk_in[LANES*b+i];
      i_round = rnd;
      i_valid = 1'b1;
      cyc = 0;
      @(negedge i_clk);
      while (!o_ready && cyc < 50) begin
        @(negedge i_clk);
        cyc++;
      end
      if (!o_ready) begin
        failNow("input_handshake");
        i_valid = 1'b0;
        return;
      end
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic waitEmpty();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(posedge i_clk);
      cyc++;
    end
    if (sb.size() != 0) begin
      failNow("drain");
      sb.delete();
    end
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    sb.delete();
    checkOutput("rst_o_ready", 64'(o_ready), 64'd0);
    checkOutput("rst_o_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_o_last", 64'(o_last), 64'd0);
    checkOutput("rst_o_mx_vec", 64'(o_mx_vec), 64'd0);
    checkOutput("rst_o_mx_exp", 64'(o_mx_exp), 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("post_rst_o_ready", 64'(o_ready), 64'd1);
  endtask

  task automatic setMixed(input logic rnd);
    fillAll(16'h3F80, 8'h10);
    blk_in[20] = 16'h4080; exp_el[20] = 8'h40;
    blk_in[1]  = 16'hBF80; exp_el[1]  = 8'hF0;
    blk_in[9]  = 16'h3DC0; exp_el[9]  = rnd ? 8'h02 : 8'h01;
    blk_in[30] = 16'h3D00; exp_el[30] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();

    // All 1.0, RNE, with latency check after the final input beat.
    fillAll(16'h3F80, 8'h40);
    pushExpected(8'h7F);
    applyStimulus(1'b1, BEATS);
    checkOutput("scale_o_valid", 64'(o_valid), 64'd0);
    checkOutput("scale_o_ready", 64'(o_ready), 64'd0);
    @(posedge i_clk);
    #1;
    checkOutput("latency_o_valid", 64'(o_valid), 64'd1);
    waitEmpty();

    // Mixed values, max 4.0, both rounding modes.
    setMixed(1'b1);
    pushExpected(8'h81);
    applyStimulus(1'b1, BEATS);
    waitEmpty();
    setMixed(1'b0);
    pushExpected(8'h81);
    applyStimulus(1'b0, BEATS);
    waitEmpty();

    // Saturation.
    fillAll(16'h3FFF, 8'h7F);
    pushExpected(8'h7F);
    applyStimulus(1'b1, BEATS);
    waitEmpty();
    pushExpected(8'h7F);
    applyStimulus(1'b0, BEATS);
    waitEmpty();
    fillAll(16'hBFFF, 8'h81);
    pushExpected(8'h7F);
    applyStimulus(1'b1, BEATS);
    waitEmpty();

    // Specials: a NaN poisons the block; zero/subnormal block gives exp 0.
    fillAll(16'h3F80, 8'h00);
    blk_in[13] = 16'h7FC0;
    pushExpected(8'hFF);
    applyStimulus(1'b1, BEATS);
    waitEmpty();
    for (int i = 0; i < K; i++) begin
      blk_in[i] = (i % 2 == 0) ? 16'h0000 : 16'h8001;
      exp_el[i] = 8'h00;
    end
    pushExpected(8'h00);
    applyStimulus(1'b1, BEATS);
    waitEmpty();

    // Backpressure on beat 1, with ignored input pulses during DRAIN.
    setMixed(1'b1);
    pushExpected(8'h81);
    i_ready = 1'b0;
    applyStimulus(1'b1, BEATS);
    begin
      int cyc;
      cyc = 0;
      @(negedge i_clk);
      while (!o_valid && cyc < 20) begin
        @(negedge i_clk);
        cyc++;
      end
      if (!o_valid) failNow("bp_first_valid");
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checkOutput("bp_vec", 64'(o_mx_vec), 64'(expBeat(0)));
      checkOutput("bp_exp", 64'(o_mx_exp), 64'h81);
      checkOutput("bp_last", 64'(o_last), 64'd0);
      checkOutput("bp_o_ready", 64'(o_ready), 64'd0);
      checkOutput("bp_o_valid", 64'(o_valid), 64'd1);
      i_bf16_vec = {LANES{16'h7FC0}};
      i_valid = (c != 1);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    waitEmpty();
    fillAll(16'h3F80, 8'h40);
    pushExpected(8'h7F);
    applyStimulus(1'b1, BEATS);
    waitEmpty();

    // Reset mid-fill discards a NaN-carrying partial block.
    fillAll(16'h3F80, 8'h40);
    blk_in[3] = 16'h7FC0;
    applyStimulus(1'b1, 2);
    doReset();
    fillAll(16'h3F80, 8'h40);
    pushExpected(8'h7F);
    applyStimulus(1'b1, BEATS);
    waitEmpty();

    if (sb.size() != 0) failNow("leftover_expected");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
